// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: feeds a 16-bit prefix adder one word per cycle, LS word
// first. It chains the adder carry and assembles a W = 16*NUM_WORDS result
// with N/Z/C/V flags. The result is returned over a valid/ready handshake.
// Optional build macro ADDSEQ_PIPE_EN: when it is defined, a new request can be
// accepted in the same cycle that the current result is consumed, so the block
// goes from DONE straight back to RUN.
module wide_add_sequencer #(
    parameter int NUM_WORDS = 2,
    localparam int W = 16 * NUM_WORDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin_flag,
    output logic [15:0]  add_x,
    output logic [15:0]  add_y,
    output logic         add_c0,
    input  logic [15:0]  add_sum,
    input  logic         add_c16,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_v
);

    localparam int KW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t        r_state;
    logic [KW-1:0] r_k;
    logic [W-1:0]  r_a_sh;      // remaining A words, next word in [15:0]
    logic [W-1:0]  r_y_sh;      // remaining effective-B words
    logic          r_a_msb;
    logic          r_y_msb;
    logic [15:0]   r_add_x;
    logic [15:0]   r_add_y;
    logic          r_add_c0;    // doubles as the inter-word carry register
    logic [W-1:0]  r_result;
    logic          r_flag_n;
    logic          r_flag_z;
    logic          r_flag_c;
    logic          r_flag_v;
    logic          r_out_valid;
    logic          r_in_ready;

    logic [W-1:0]  w_yeff;
    logic          w_c0_first;
    logic [W-1:0]  w_res_next;
    logic          w_accept;
    logic          w_pipe_ready;

    // Operand conditioning: SUB/SBC invert B; pick the word-0 carry-in per op
    always_comb begin
        w_yeff     = b;
        w_c0_first = 1'b0;
        case (op)
            2'b00:   begin w_yeff = b;  w_c0_first = 1'b0;     end
            2'b01:   begin w_yeff = ~b; w_c0_first = 1'b1;     end
            2'b10:   begin w_yeff = b;  w_c0_first = cin_flag; end
            2'b11:   begin w_yeff = ~b; w_c0_first = cin_flag; end
            default: begin w_yeff = b;  w_c0_first = 1'b0;     end
        endcase
    end

    // Result with the current adder word merged in at word position r_k
    always_comb begin
        w_res_next = r_result;
        w_res_next[{r_k, 4'b0000} +: 16] = add_sum;
    end

    // Request acceptance, including the same-cycle hand-off out of DONE
    always_comb begin
        w_accept     = 1'b0;
        w_pipe_ready = 1'b0;
`ifdef ADDSEQ_PIPE_EN
        if (r_state == ST_DONE) begin
            w_pipe_ready = out_ready;
            w_accept     = out_ready & in_valid;
        end else if (r_state == ST_IDLE) begin
            w_accept = in_valid;
        end else begin
            w_accept = 1'b0;
        end
`else
        if (r_state == ST_IDLE) begin
            w_accept = in_valid;
        end else begin
            w_accept = 1'b0;
        end
`endif
    end

    // Sequencer FSM: latch the request, step through the words, hold the result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_k         <= {KW{1'b0}};
            r_a_sh      <= {W{1'b0}};
            r_y_sh      <= {W{1'b0}};
            r_a_msb     <= 1'b0;
            r_y_msb     <= 1'b0;
            r_add_x     <= 16'h0000;
            r_add_y     <= 16'h0000;
            r_add_c0    <= 1'b0;
            r_result    <= {W{1'b0}};
            r_flag_n    <= 1'b0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (w_accept) begin
            // The word-0 operands go straight to the adder; the rest wait in the shifters
            r_add_x     <= a[15:0];
            r_add_y     <= w_yeff[15:0];
            r_add_c0    <= w_c0_first;
            r_a_sh      <= a >> 16;
            r_y_sh      <= w_yeff >> 16;
            r_a_msb     <= a[W-1];
            r_y_msb     <= w_yeff[W-1];
            r_k         <= {KW{1'b0}};
            r_state     <= ST_RUN;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                end
                ST_RUN: begin
                    r_result <= w_res_next;
                    r_k      <= r_k + KW'(1);
                    if (r_k == LAST_K) begin
                        r_flag_n    <= w_res_next[W-1];
                        r_flag_z    <= (w_res_next == {W{1'b0}});
                        r_flag_c    <= add_c16;
                        r_flag_v    <= (r_a_msb == r_y_msb) && (w_res_next[W-1] != r_a_msb);
                        r_add_x     <= 16'h0000;
                        r_add_y     <= 16'h0000;
                        r_add_c0    <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_add_x  <= r_a_sh[15:0];
                        r_add_y  <= r_y_sh[15:0];
                        r_add_c0 <= add_c16;
                        r_a_sh   <= r_a_sh >> 16;
                        r_y_sh   <= r_y_sh >> 16;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_add_x     <= 16'h0000;
                    r_add_y     <= 16'h0000;
                    r_add_c0    <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready | w_pipe_ready;
    assign out_valid = r_out_valid;
    assign add_x     = r_add_x;
    assign add_y     = r_add_y;
    assign add_c0    = r_add_c0;
    assign result    = r_result;
    assign flag_n    = r_flag_n;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Testbench for wide_add_sequencer (NUM_WORDS=2). It models the 16-bit adder
// and checks table vectors, hand-written corner sequences, and random operations.
// The random operations are checked against a whole-width arithmetic reference.
module tb_wide_add_sequencer;

    localparam int NW = 2;
    localparam int W  = 16 * NW;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin_flag;
    logic [15:0]  add_x;
    logic [15:0]  add_y;
    logic         add_c0;
    logic [15:0]  add_sum;
    logic         add_c16;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_n;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural 16-bit adder sitting downstream of the sequencer
    assign {add_c16, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {16'h0000, add_c0};

    wide_add_sequencer #(.NUM_WORDS(NW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .cin_flag(cin_flag),
        .add_x(add_x), .add_y(add_y), .add_c0(add_c0),
        .add_sum(add_sum), .add_c16(add_c16),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic [3:0]   nzcv;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, got, exp);
        end
    endtask

    // Whole-width reference: a + (b or ~b) + carry-in, flags from the definitions
    function automatic void model(input logic [1:0] mop, input logic [W-1:0] ma,
                                  input logic [W-1:0] mb, input logic mcin,
                                  output logic [W-1:0] mres, output logic [3:0] mnzcv);
        logic [W-1:0] y;
        logic         c0;
        logic [W:0]   s;
        y  = (mop == 2'b01 || mop == 2'b11) ? ~mb : mb;
        c0 = (mop == 2'b00) ? 1'b0 : ((mop == 2'b01) ? 1'b1 : mcin);
        s  = {1'b0, ma} + {1'b0, y} + {{W{1'b0}}, c0};
        mres  = s[W-1:0];
        mnzcv = {s[W-1], (s[W-1:0] == {W{1'b0}}), s[W],
                 (ma[W-1] == y[W-1]) && (s[W-1] != ma[W-1])};
    endfunction

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input logic c);
        @(negedge clk);
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; op = o; a = av; b = bv; cin_flag = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom); cin_flag = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid !== 1'b1) chk("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_result(input string nm, input logic [W-1:0] er, input logic [3:0] ef);
        chk({nm, "_result"}, {32'd0, result}, {32'd0, er});
        chk({nm, "_nzcv"}, {60'd0, flag_n, flag_z, flag_c, flag_v}, {60'd0, ef});
    endtask

    vec_t vecs[5];

    initial begin
        int lat;
        logic [W-1:0] er;
        logic [3:0]   ef;
        logic [W-1:0] hold_r;
        logic [3:0]   hold_f;
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        vecs[0] = '{2'b00, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 4'b0000};
        vecs[1] = '{2'b01, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 4'b0110};
        vecs[2] = '{2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b1001};
        vecs[3] = '{2'b10, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b0110};
        vecs[4] = '{2'b11, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 4'b1000};

        reset = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0;
        cin_flag = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'd0);
        chk("rst_adder", {47'd0, add_x, add_y, add_c0}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Word-level carry chaining: word 0 overflows into word 1
        start_op(2'b00, 32'h0000FFFF, 32'h00000001, 1'b0);
        chk("w0_add_x", {48'd0, add_x}, 64'h0000_0000_0000_FFFF);
        chk("w0_add_c0", {63'd0, add_c0}, 64'd0);
        @(posedge clk);
        #1;
        chk("w1_add_c0", {63'd0, add_c0}, 64'd1);
        chk("w1_add_x", {48'd0, add_x}, 64'd0);
        chk("w1_out_valid", {63'd0, out_valid}, 64'd0);
        wait_done(lat);
        chk("w_latency", 64'(lat), 64'(NW - 1));
        check_result("chain", 32'h00010000, 4'b0000);
        @(posedge clk);
        #1;

        // Test-plan vectors
        for (int i = 0; i < 5; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done(lat);
            chk("vec_latency", 64'(lat), 64'(NW));
            check_result($sformatf("vec%0d", i), vecs[i].res, vecs[i].nzcv);
            chk("vec_done_adder", {47'd0, add_x, add_y, add_c0}, 64'd0);
            @(posedge clk);
            #1;
            chk("vec_back_idle", {62'd0, out_valid, in_ready}, 64'd1);
        end

        // Back-pressure: DONE holds while inputs churn and in_valid pulses
        out_ready = 1'b0;
        start_op(2'b01, 32'h12345678, 32'h23456789, 1'b0);
        model(2'b01, 32'h12345678, 32'h23456789, 1'b0, er, ef);
        wait_done(lat);
        hold_r = result;
        hold_f = {flag_n, flag_z, flag_c, flag_v};
        check_result("bp_first", er, ef);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; in_valid = i[0];
            #1;
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check_result("bp_hold", hold_r, hold_f);
        end
        @(negedge clk);
        in_valid = 1'b0;

`ifdef ADDSEQ_PIPE_EN
        // Same-cycle consume and accept goes straight back to RUN
        out_ready = 1'b1; in_valid = 1'b1; op = 2'b00;
        a = 32'h0001_00A0; b = 32'h0002_0005; cin_flag = 1'b0;
        #1;
        chk("pipe_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pipe_run", {62'd0, out_valid, in_ready}, 64'd0);
        chk("pipe_add_x", {48'd0, add_x}, 64'h00A0);
        wait_done(lat);
        chk("pipe_latency", 64'(lat), 64'(NW));
        check_result("pipe", 32'h0003_00A5, 4'b0000);
        @(posedge clk);
        #1;
`else
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", {62'd0, out_valid, in_ready}, 64'd1);
`endif

        // Reset during the word-0 RUN cycle aborts the operation
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_result", {32'd0, result}, 64'd0);
        chk("mid_rst_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'd0);
        chk("mid_rst_adder", {47'd0, add_x, add_y, add_c0}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Random operations against the reference model
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
            if (i % 10 == 0) ra = 32'h8000_0000;
            if (i % 10 == 1) rb = ra;
            model(ro, ra, rb, rc, er, ef);
            start_op(ro, ra, rb, rc);
            wait_done(lat);
            chk("rnd_latency", 64'(lat), 64'(NW));
            check_result($sformatf("rnd%0d", i), er, ef);
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
